// File: rtl/multicycle_main_fsm.sv
// Main control FSM for a multicycle ARM-style datapath. The FSM is Moore: every
// output is decoded from the state register, plus the latched long-multiply flag.
module multicycle_main_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Op,
  input  logic [5:0]  Funct,
  input  logic        IsMul,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic        NextPC,
  output logic        RegW,
  output logic        MemW,
  output logic        Branch,
  output logic        ALUOp,
  output logic        opMul,
  output logic        IsLongMul,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [3:0]  State,
  output logic [31:0] RetiredCount
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_MULEX    = 4'd10,
    S_MULWB    = 4'd11,
    S_UNKNOWN  = 4'd15
  } state_e;

  state_e      state_q, state_d;
  logic        long_q, long_d;
  logic [31:0] retired_q, retired_d;
  logic        retire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      long_q    <= 1'b0;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      long_q    <= long_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b00: begin
            if (IsMul)         state_d = S_MULEX;
            else if (Funct[5]) state_d = S_EXECUTEI;
            else               state_d = S_EXECUTER;
          end
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR:   state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_MULEX:    state_d = S_MULWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // The long flag is only sampled as a multiply leaves DECODE, so Funct may
  // change afterwards without disturbing the in-flight multiply.
  always_comb begin
    long_d = long_q;
    if (state_q == S_DECODE && state_d == S_MULEX) long_d = Funct[3];
  end

  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_MULWB: retire = 1'b1;
      default: retire = 1'b0;
    endcase
    retired_d = retire ? retired_q + 32'd1 : retired_q;
  end

  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    opMul     = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR:   ALUSrcB = 2'b01;
      S_MEMRD:    AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      S_EXECUTER: ALUOp = 1'b1;
      S_EXECUTEI: begin
        ALUOp   = 1'b1;
        ALUSrcB = 2'b01;
      end
      S_ALUWB:    RegW = 1'b1;
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
      end
      S_MULEX: begin
        ALUOp = 1'b1;
        opMul = 1'b1;
      end
      S_MULWB: begin
        opMul = 1'b1;
        RegW  = 1'b1;
      end
      default: ;
    endcase
  end

  assign IsLongMul    = long_q & ((state_q == S_MULEX) | (state_q == S_MULWB));
  assign State        = state_q;
  assign RetiredCount = retired_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed bench for multicycle_main_fsm: walks each instruction class through
// its state sequence and checks state codes, key controls and the retire count.
module tb_multicycle_main_fsm;

  logic        clk;
  logic        reset;
  logic [1:0]  Op;
  logic [5:0]  Funct;
  logic        IsMul;
  logic        IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, Branch, ALUOp, opMul, IsLongMul;
  logic [1:0]  ALUSrcB, ResultSrc;
  logic [3:0]  State;
  logic [31:0] RetiredCount;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_ret = 32'd0;

  multicycle_main_fsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .IsMul(IsMul),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .NextPC(NextPC),
    .RegW(RegW), .MemW(MemW), .Branch(Branch), .ALUOp(ALUOp), .opMul(opMul),
    .IsLongMul(IsLongMul), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .State(State), .RetiredCount(RetiredCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; Op = 2'b00; Funct = 6'd0; IsMul = 1'b0;
    tick();
    tick();
    total++;
    if (State !== 4'd0 || RetiredCount !== 32'd0) begin
      bad++; $display("FAIL reset_state got state=%0d ret=%0d exp state=0 ret=0", State, RetiredCount);
    end
    total++;
    if ({IRWrite, NextPC, ALUSrcA, ALUSrcB, ResultSrc, RegW, MemW, Branch, AdrSrc, ALUOp, opMul, IsLongMul}
        !== 14'b1_1_1_10_10_0_0_0_0_0_0_0) begin
      bad++; $display("FAIL reset_outputs got IRW=%b NPC=%b SA=%b SB=%b RS=%b RegW=%b MemW=%b Br=%b exp FETCH decode",
                      IRWrite, NextPC, ALUSrcA, ALUSrcB, ResultSrc, RegW, MemW, Branch);
    end
  endtask

  task automatic test_dp();
    logic [3:0] exp_s [4] = '{4'd1, 4'd6, 4'd8, 4'd0};
    Op = 2'b00; Funct = 6'b000000; IsMul = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (State !== exp_s[i]) begin
        bad++; $display("FAIL dp_state step%0d got=%0d exp=%0d", i, State, exp_s[i]);
      end
      total++;
      if (RegW !== (exp_s[i] == 4'd8)) begin
        bad++; $display("FAIL dp_regw step%0d got=%b exp=%b", i, RegW, exp_s[i] == 4'd8);
      end
      if (exp_s[i] == 4'd6) begin
        total++;
        if (ALUOp !== 1'b1 || ALUSrcB !== 2'b00) begin
          bad++; $display("FAIL dp_exec got ALUOp=%b SB=%b exp 1 00", ALUOp, ALUSrcB);
        end
      end
      if (exp_s[i] == 4'd8) begin
        total++;
        if (RetiredCount !== exp_ret) begin
          bad++; $display("FAIL dp_early_retire got=%0d exp=%0d", RetiredCount, exp_ret);
        end
      end
    end
    exp_ret = exp_ret + 1;
    total++;
    if (RetiredCount !== exp_ret) begin
      bad++; $display("FAIL dp_retired got=%0d exp=%0d", RetiredCount, exp_ret);
    end
    // Immediate-form DP goes through EXECUTEI with ALUSrcB=01
    Funct = 6'b100000;
    tick();
    tick();
    total++;
    if (State !== 4'd7 || ALUSrcB !== 2'b01 || ALUOp !== 1'b1) begin
      bad++; $display("FAIL dpi_exec got state=%0d SB=%b ALUOp=%b exp 7 01 1", State, ALUSrcB, ALUOp);
    end
    tick();
    tick();
    exp_ret = exp_ret + 1;
    total++;
    if (State !== 4'd0 || RetiredCount !== exp_ret) begin
      bad++; $display("FAIL dpi_end got state=%0d ret=%0d exp 0 %0d", State, RetiredCount, exp_ret);
    end
  endtask

  task automatic test_mem();
    logic [3:0] ld_s [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    logic [3:0] st_s [4] = '{4'd1, 4'd2, 4'd5, 4'd0};
    Op = 2'b01; Funct = 6'b000001; IsMul = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (State !== ld_s[i]) begin
        bad++; $display("FAIL ldr_state step%0d got=%0d exp=%0d", i, State, ld_s[i]);
      end
      if (ld_s[i] == 4'd2) begin
        total++;
        if (ALUSrcB !== 2'b01) begin
          bad++; $display("FAIL ldr_memadr got SB=%b exp=01", ALUSrcB);
        end
      end
      if (ld_s[i] == 4'd3) begin
        total++;
        if (AdrSrc !== 1'b1 || RegW !== 1'b0) begin
          bad++; $display("FAIL ldr_memrd got AdrSrc=%b RegW=%b exp 1 0", AdrSrc, RegW);
        end
      end
      if (ld_s[i] == 4'd4) begin
        total++;
        if (ResultSrc !== 2'b01 || RegW !== 1'b1) begin
          bad++; $display("FAIL ldr_memwb got RS=%b RegW=%b exp 01 1", ResultSrc, RegW);
        end
      end
    end
    exp_ret = exp_ret + 1;
    Funct = 6'b000000;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (State !== st_s[i]) begin
        bad++; $display("FAIL str_state step%0d got=%0d exp=%0d", i, State, st_s[i]);
      end
      total++;
      if (MemW !== (st_s[i] == 4'd5)) begin
        bad++; $display("FAIL str_memw step%0d got=%b exp=%b", i, MemW, st_s[i] == 4'd5);
      end
    end
    exp_ret = exp_ret + 1;
    total++;
    if (RetiredCount !== exp_ret) begin
      bad++; $display("FAIL mem_retired got=%0d exp=%0d", RetiredCount, exp_ret);
    end
  endtask

  task automatic test_mul();
    logic [3:0] ms [4] = '{4'd1, 4'd10, 4'd11, 4'd0};
    logic       lng;
    for (int pass = 0; pass < 2; pass++) begin
      Op = 2'b00; IsMul = 1'b1;
      Funct = (pass == 0) ? 6'b001000 : 6'b000000;
      for (int i = 0; i < 4; i++) begin
        tick();
        // Flipping Funct[3] mid-multiply must not change the latched flag
        if (ms[i] == 4'd10) Funct = (pass == 0) ? 6'b000000 : 6'b001000;
        lng = (pass == 0) && (ms[i] == 4'd10 || ms[i] == 4'd11);
        total++;
        if (State !== ms[i]) begin
          bad++; $display("FAIL mul%0d_state step%0d got=%0d exp=%0d", pass, i, State, ms[i]);
        end
        total++;
        if (IsLongMul !== lng) begin
          bad++; $display("FAIL mul%0d_long step%0d got=%b exp=%b", pass, i, IsLongMul, lng);
        end
        total++;
        if (opMul !== (ms[i] == 4'd10 || ms[i] == 4'd11)) begin
          bad++; $display("FAIL mul%0d_opmul step%0d got=%b", pass, i, opMul);
        end
        if (ms[i] == 4'd11) begin
          total++;
          if (RegW !== 1'b1 || ALUOp !== 1'b0) begin
            bad++; $display("FAIL mul%0d_wb got RegW=%b ALUOp=%b exp 1 0", pass, RegW, ALUOp);
          end
        end
      end
      exp_ret = exp_ret + 1;
    end
    total++;
    if (RetiredCount !== exp_ret) begin
      bad++; $display("FAIL mul_retired got=%0d exp=%0d", RetiredCount, exp_ret);
    end
  endtask

  task automatic test_branch_unknown();
    logic [3:0] bs [3] = '{4'd1, 4'd9, 4'd0};
    logic [3:0] us [3] = '{4'd1, 4'd15, 4'd0};
    Op = 2'b10; Funct = 6'd0; IsMul = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (State !== bs[i] || Branch !== (bs[i] == 4'd9)) begin
        bad++; $display("FAIL b_step%0d got state=%0d Branch=%b exp %0d %b", i, State, Branch, bs[i], bs[i] == 4'd9);
      end
    end
    exp_ret = exp_ret + 1;
    Op = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (State !== us[i]) begin
        bad++; $display("FAIL unk_state step%0d got=%0d exp=%0d", i, State, us[i]);
      end
      if (us[i] == 4'd15) begin
        total++;
        if ({IRWrite, NextPC, RegW, MemW, Branch} !== 5'b0) begin
          bad++; $display("FAIL unk_enables got=%b exp=00000", {IRWrite, NextPC, RegW, MemW, Branch});
        end
      end
    end
    total++;
    if (RetiredCount !== exp_ret) begin
      bad++; $display("FAIL bu_retired got=%0d exp=%0d", RetiredCount, exp_ret);
    end
  endtask

  task automatic test_async_reset();
    Op = 2'b01; Funct = 6'b000001; IsMul = 1'b0;
    tick(); tick(); tick();
    total++;
    if (State !== 4'd3) begin
      bad++; $display("FAIL ar_pre got=%0d exp=3", State);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (State !== 4'd0 || RetiredCount !== 32'd0 || IRWrite !== 1'b1) begin
      bad++; $display("FAIL ar_async got state=%0d ret=%0d IRW=%b exp 0 0 1", State, RetiredCount, IRWrite);
    end
    exp_ret = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    Op = 2'b00; Funct = 6'd0;
    tick();
    total++;
    if (State !== 4'd1 || RetiredCount !== 32'd0) begin
      bad++; $display("FAIL ar_release got state=%0d ret=%0d exp 1 0", State, RetiredCount);
    end
    tick(); tick(); tick();
    exp_ret = exp_ret + 1;
    total++;
    if (State !== 4'd0 || RetiredCount !== exp_ret) begin
      bad++; $display("FAIL ar_after got state=%0d ret=%0d exp 0 %0d", State, RetiredCount, exp_ret);
    end
  endtask

  task automatic test_wrap();
    Op = 2'b00; Funct = 6'd0; IsMul = 1'b0;
    tick(); tick(); tick();
    force dut.retired_q = 32'hFFFF_FFFF;
    #1 release dut.retired_q;
    #1;
    total++;
    if (State !== 4'd8 || RetiredCount !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL wrap_preload got state=%0d ret=%h exp 8 ffffffff", State, RetiredCount);
    end
    tick();
    total++;
    if (State !== 4'd0 || RetiredCount !== 32'd0) begin
      bad++; $display("FAIL wrap got state=%0d ret=%h exp 0 00000000", State, RetiredCount);
    end
  endtask

  initial begin
    test_reset();
    test_dp();
    test_mem();
    test_mul();
    test_branch_unknown();
    test_async_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
